// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional load-use stall counter is built only when STALL_COUNT_EN is defined.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ID,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic [4:0]  rd_ID,
    input  logic        rs_used_ID,
    input  logic        rt_used_ID,
    input  logic        we_ID,
    input  logic        memread_ID,
    input  logic        memwrite_ID,
    input  logic [3:0]  aluop_ID,
    input  logic [31:0] pc_ID,
    input  logic [31:0] rdata1_ID,
    input  logic [31:0] rdata2_ID,
    input  logic [31:0] imm_ID,
    input  logic        flush,
    output logic        valid_ID_EX,
    output logic [4:0]  rs_ID_EX,
    output logic [4:0]  rt_ID_EX,
    output logic [4:0]  rd_ID_EX,
    output logic        rs_used_ID_EX,
    output logic        rt_used_ID_EX,
    output logic        we_ID_EX,
    output logic        memread_ID_EX,
    output logic        memwrite_ID_EX,
    output logic [3:0]  aluop_ID_EX,
    output logic [31:0] pc_ID_EX,
    output logic [31:0] rdata1_ID_EX,
    output logic [31:0] rdata2_ID_EX,
    output logic [31:0] imm_ID_EX,
    output logic        stall,
    output logic [31:0] stall_count
);

    logic load_use;
    logic bubble;
    logic we_q;
    logic memwrite_q;

    always_comb begin
        load_use = valid_ID && memread_ID_EX && valid_ID_EX && (rd_ID_EX != 5'd0) &&
                   ((rs_used_ID && (rs_ID == rd_ID_EX)) || (rt_used_ID && (rt_ID == rd_ID_EX)));
        // Gated by rst_n so stall never shows while reset is held.
        stall  = rst_n && load_use && !flush;
        bubble = flush || stall || !valid_ID;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            valid_ID_EX   <= 1'b0;
            rs_ID_EX      <= '0;
            rt_ID_EX      <= '0;
            rd_ID_EX      <= '0;
            rs_used_ID_EX <= 1'b0;
            rt_used_ID_EX <= 1'b0;
            we_q          <= 1'b0;
            memread_ID_EX <= 1'b0;
            memwrite_q    <= 1'b0;
            aluop_ID_EX   <= '0;
            pc_ID_EX      <= '0;
            rdata1_ID_EX  <= '0;
            rdata2_ID_EX  <= '0;
            imm_ID_EX     <= '0;
        end else begin
            valid_ID_EX   <= 1'b1;
            rs_ID_EX      <= rs_ID;
            rt_ID_EX      <= rt_ID;
            rd_ID_EX      <= rd_ID;
            rs_used_ID_EX <= rs_used_ID;
            rt_used_ID_EX <= rt_used_ID;
            we_q          <= we_ID;
            memread_ID_EX <= memread_ID;
            memwrite_q    <= memwrite_ID;
            aluop_ID_EX   <= aluop_ID;
            pc_ID_EX      <= pc_ID;
            rdata1_ID_EX  <= rdata1_ID;
            rdata2_ID_EX  <= rdata2_ID;
            imm_ID_EX     <= imm_ID;
        end
    end

    // Architectural side effects are only ever visible for a real instruction.
    assign we_ID_EX       = we_q && valid_ID_EX;
    assign memwrite_ID_EX = memwrite_q && valid_ID_EX;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stall) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a behavioural pipeline-slot model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ID, rs_used_ID, rt_used_ID, we_ID, memread_ID, memwrite_ID, flush;
    logic [4:0]  rs_ID, rt_ID, rd_ID;
    logic [3:0]  aluop_ID;
    logic [31:0] pc_ID, rdata1_ID, rdata2_ID, imm_ID;
    logic        valid_ID_EX, rs_used_ID_EX, rt_used_ID_EX, we_ID_EX, memread_ID_EX;
    logic        memwrite_ID_EX, stall;
    logic [4:0]  rs_ID_EX, rt_ID_EX, rd_ID_EX;
    logic [3:0]  aluop_ID_EX;
    logic [31:0] pc_ID_EX, rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX, stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        rs_used, rt_used, we, memread, memwrite;
        logic [3:0]  aluop;
        logic [31:0] pc, r1, r2, imm;
    } slot_t;

    slot_t       ex;
    logic [31:0] cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
        .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID),
        .we_ID(we_ID), .memread_ID(memread_ID), .memwrite_ID(memwrite_ID),
        .aluop_ID(aluop_ID), .pc_ID(pc_ID), .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID),
        .imm_ID(imm_ID), .flush(flush),
        .valid_ID_EX(valid_ID_EX), .rs_ID_EX(rs_ID_EX), .rt_ID_EX(rt_ID_EX),
        .rd_ID_EX(rd_ID_EX), .rs_used_ID_EX(rs_used_ID_EX), .rt_used_ID_EX(rt_used_ID_EX),
        .we_ID_EX(we_ID_EX), .memread_ID_EX(memread_ID_EX), .memwrite_ID_EX(memwrite_ID_EX),
        .aluop_ID_EX(aluop_ID_EX), .pc_ID_EX(pc_ID_EX), .rdata1_ID_EX(rdata1_ID_EX),
        .rdata2_ID_EX(rdata2_ID_EX), .imm_ID_EX(imm_ID_EX), .stall(stall),
        .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Hazard: ID needs a register that the load in EX has not produced yet.
    function automatic logic model_stall();
        logic hit;
        hit = (rs_used_ID && rs_ID == ex.rd) || (rt_used_ID && rt_ID == ex.rd);
        return rst_n && valid_ID && ex.valid && ex.memread && ex.rd != 0 && hit && !flush;
    endfunction

    task automatic check_outputs();
        check("valid", {31'd0, valid_ID_EX}, {31'd0, ex.valid});
        check("rs", {27'd0, rs_ID_EX}, {27'd0, ex.rs});
        check("rt", {27'd0, rt_ID_EX}, {27'd0, ex.rt});
        check("rd", {27'd0, rd_ID_EX}, {27'd0, ex.rd});
        check("rs_used", {31'd0, rs_used_ID_EX}, {31'd0, ex.rs_used});
        check("rt_used", {31'd0, rt_used_ID_EX}, {31'd0, ex.rt_used});
        check("we", {31'd0, we_ID_EX}, {31'd0, ex.we});
        check("memread", {31'd0, memread_ID_EX}, {31'd0, ex.memread});
        check("memwrite", {31'd0, memwrite_ID_EX}, {31'd0, ex.memwrite});
        check("aluop", {28'd0, aluop_ID_EX}, {28'd0, ex.aluop});
        check("pc", pc_ID_EX, ex.pc);
        check("rdata1", rdata1_ID_EX, ex.r1);
        check("rdata2", rdata2_ID_EX, ex.r2);
        check("imm", imm_ID_EX, ex.imm);
        check("stall_count", stall_count, cnt);
    endtask

    // Inputs are held from just after one rising edge to just after the next.
    task automatic cycle(input string tag, input int exp_stall);
        logic  s;
        slot_t nxt;
        @(negedge clk);
        s = model_stall();
        check({tag, ":stall"}, {31'd0, stall}, {31'd0, s});
        if (exp_stall >= 0) check({tag, ":stall_dir"}, {31'd0, stall}, exp_stall[31:0]);
        if (!rst_n || flush || s || !valid_ID) begin
            nxt = '0;
        end else begin
            nxt = '{1'b1, rs_ID, rt_ID, rd_ID, rs_used_ID, rt_used_ID, we_ID, memread_ID,
                    memwrite_ID, aluop_ID, pc_ID, rdata1_ID, rdata2_ID, imm_ID};
        end
        @(posedge clk);
        #1;
        ex = nxt;
`ifdef STALL_COUNT_EN
        if (!rst_n) cnt = 0;
        else if (s) cnt = cnt + 1;
`endif
        check_outputs();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic rsu, input logic rtu,
                             input logic we, input logic mr, input logic [31:0] pc);
        valid_ID = v; rs_ID = rs; rt_ID = rt; rd_ID = rd; rs_used_ID = rsu; rt_used_ID = rtu;
        we_ID = we; memread_ID = mr; memwrite_ID = 1'b0; aluop_ID = mr ? 4'd0 : 4'd2;
        pc_ID = pc; rdata1_ID = pc ^ 32'h1111; rdata2_ID = pc ^ 32'h2222; imm_ID = pc + 4;
        flush = 1'b0;
    endtask

    initial begin
        ex = '0;
        cnt = 0;
        rst_n = 1'b0;
        set_instr(1, 1, 2, 3, 1, 1, 1, 1, 32'h10);
        cycle("reset", 0);
        rst_n = 1'b1;

        // ALU instruction passes straight through.
        set_instr(1, 1, 2, 5, 1, 1, 1, 0, 32'h0000_3000);
        cycle("alu", 0);
        check("alu_pc", pc_ID_EX, 32'h0000_3000);
        check("alu_rd", {27'd0, rd_ID_EX}, 32'd5);

        // lw $8 then dependent add: one stall, one bubble, then the add enters.
        set_instr(1, 4, 8, 8, 1, 0, 1, 1, 32'h100);
        cycle("lw8", 0);
        set_instr(1, 8, 3, 10, 1, 1, 1, 0, 32'h104);
        cycle("lu_stall", 1);
        check("lu_bubble", {31'd0, valid_ID_EX}, 32'd0);
        cycle("lu_go", 0);
        check("lu_rs", {27'd0, rs_ID_EX}, 32'd8);

        // Load to $0 never creates a hazard.
        set_instr(1, 1, 0, 0, 1, 0, 1, 1, 32'h200);
        cycle("lw0", 0);
        set_instr(1, 0, 0, 6, 1, 1, 1, 0, 32'h204);
        cycle("rd0", 0);

        // Matching rt that is not read does not stall.
        set_instr(1, 1, 9, 9, 1, 0, 1, 1, 32'h300);
        cycle("lw9", 0);
        set_instr(1, 2, 9, 9, 1, 0, 1, 0, 32'h304);
        cycle("rt_unused", 0);

        // Flush beats a live hazard.
        set_instr(1, 1, 7, 7, 1, 0, 1, 1, 32'h400);
        cycle("lw7", 0);
        set_instr(1, 7, 7, 11, 1, 1, 1, 0, 32'h404);
        flush = 1'b1;
        cycle("flush", 0);
        check("flush_we", {31'd0, we_ID_EX}, 32'd0);

        // Reset during a stall cycle.
        set_instr(1, 1, 12, 12, 1, 0, 1, 1, 32'h500);
        cycle("lw12", 0);
        set_instr(1, 12, 0, 13, 1, 0, 1, 0, 32'h504);
        cycle("pre_rst_stall", 1);
        set_instr(1, 1, 12, 12, 1, 0, 1, 1, 32'h508);
        cycle("lw12b", 0);
        set_instr(1, 12, 0, 13, 1, 0, 1, 0, 32'h50c);
        rst_n = 1'b0;
        cycle("rst_mid_stall", 0);
        check("rst_cnt", stall_count, 32'd0);
        rst_n = 1'b1;

        // Random traffic on a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = $urandom_range(0, 63) != 0;
            valid_ID    = $urandom_range(0, 7) != 0;
            rs_ID       = 5'($urandom_range(0, 3));
            rt_ID       = 5'($urandom_range(0, 3));
            rd_ID       = 5'($urandom_range(0, 3));
            rs_used_ID  = $urandom_range(0, 3) != 0;
            rt_used_ID  = $urandom_range(0, 1) != 0;
            we_ID       = 1'($urandom);
            memread_ID  = $urandom_range(0, 2) == 0;
            memwrite_ID = 1'($urandom);
            aluop_ID    = 4'($urandom);
            pc_ID       = $urandom;
            rdata1_ID   = $urandom;
            rdata2_ID   = $urandom;
            imm_ID      = $urandom;
            flush       = $urandom_range(0, 7) == 0;
            cycle("rand", -1);
            if (!valid_ID_EX) begin
                check("gate_we", {31'd0, we_ID_EX}, 32'd0);
                check("gate_mw", {31'd0, memwrite_ID_EX}, 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: valid_ID  input  1  ID stage holds a real instruction.
REQ-004 SHALL have ports: rs_ID, rt_ID, rd_ID  input  5 each  source and destination register numbers (rd already muxed for rt/rd/31).
REQ-005 SHALL have ports: rs_used_ID, rt_used_ID  input  1 each  instruction actually reads rs/rt.
REQ-006 SHALL have ports: we_ID, memread_ID, memwrite_ID  input  1 each  decoded control bits.
REQ-007 SHALL have port: aluop_ID  input  4  ALU operation.
REQ-008 SHALL have ports: pc_ID, rdata1_ID, rdata2_ID, imm_ID  input  32 each  datapath values.
REQ-009 SHALL have port: flush  input  1  discard the ID instruction (control transfer).
REQ-010 SHALL have ports: *_ID_EX  output  same widths as REQ-004..008  registered copies; rs_ID_EX, rt_ID_EX, rd_ID_EX, we_ID_EX feed the forwarding unit.
REQ-011 SHALL have port: valid_ID_EX  output  1  EX holds a real instruction.
REQ-012 SHALL have port: stall  output  1  hold PC and IF/ID this cycle.
REQ-013 SHALL have port: stall_count  output  32  cumulative load-use stall cycles.

Function
REQ-014 SHALL assert stall combinationally when valid_ID & memread_ID_EX & valid_ID_EX & rd_ID_EX!=0 & ((rs_used_ID & rs_ID==rd_ID_EX) | (rt_used_ID & rt_ID==rd_ID_EX)) & !flush.
REQ-015 SHALL, on a clock edge with stall=1, load a bubble: valid, we, memread, memwrite = 0, rd = 0, aluop = 0; other fields don't-care but held at 0.
REQ-016 SHALL, on a clock edge with flush=1, load a bubble as REQ-015; flush has priority over stall and over normal load.
REQ-017 SHALL, on a clock edge with valid_ID=0, load a bubble.
REQ-018 SHALL otherwise load every *_ID input into its *_ID_EX register, latency exactly one cycle.
REQ-019 SHALL gate we_ID_EX and memwrite_ID_EX so they are never 1 while valid_ID_EX=0.
REQ-020 SHALL produce at most one stall cycle per load-use pair (after the bubble, memread_ID_EX=0, so stall drops).
REQ-021 SHALL not stall for rd_ID_EX=0 even if rs/rt match 0.
REQ-022 SHALL increment stall_count by 1 on each clock edge where stall=1, wrapping 0xFFFFFFFF->0.

Reset
REQ-023 SHALL, on a rising edge with rst_n=0, clear all *_ID_EX outputs, valid_ID_EX and stall_count to 0; stall reads 0 during and after reset.
REQ-024 SHALL let reset override flush, stall and normal load in the same cycle, including mid-stall.

Configuration
REQ-025 SHALL compile the stall counter only when macro STALL_COUNT_EN is defined.
REQ-026 SHALL, without STALL_COUNT_EN, keep port stall_count and drive it constant 0, with no counter register.

Verification
REQ-027 SHALL cover: lw $8 in EX (memread=1, rd=8), ID add rs=8 rs_used=1 -> stall=1 one cycle, bubble in EX, next cycle add enters with rs_ID_EX=8, stall=0, stall_count=1.
REQ-028 SHALL cover: lw rd=0 in EX, ID rs=0 -> stall=0, normal load.
REQ-029 SHALL cover: lw rd=9 in EX, ID rt=9 rt_used=0 (e.g. addi) -> stall=0.
REQ-030 SHALL cover: load-use condition true with flush=1 -> stall=0, bubble loaded, we_ID_EX=0.
REQ-031 SHALL cover: rst_n=0 asserted during a stall cycle -> next edge all outputs 0, stall_count=0.
REQ-032 SHALL cover: ALU instr rd=5 we=1 pc=0x00003000 -> next cycle rd_ID_EX=5, we_ID_EX=1, pc_ID_EX=0x00003000, no stall.
